// File: rtl/sr_drv_pkg.sv
// rtl/sr_drv_pkg.sv - shared FSM states, synchronizer depth and request encoding for sr_latch_driver
package sr_drv_pkg;

    localparam int SYNC_DEPTH = 2;

    localparam logic [2:0] ST_INIT      = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_PULSE_SET = 3'd2;
    localparam logic [2:0] ST_PULSE_RST = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd4;

    // Request types double as bit indices into the pending/rise vectors.
    localparam int REQ_SET = 0;
    localparam int REQ_RST = 1;
    localparam int NUM_REQ = 2;

endpackage

// File: rtl/sr_debounce.sv
// rtl/sr_debounce.sv - button synchronizer, debounce counter and rising-edge detect
module sr_debounce
    import sr_drv_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [SYNC_DEPTH-1:0] sync;
    logic [CNT_W-1:0]      cnt;
    logic                  level;
    logic                  sample;

    assign sample = sync[SYNC_DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_DEPTH-2:0], raw};
            rise <= 1'b0;
            // Any sample that agrees with the current level restarts the run.
            if (sample == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sample;
                rise  <= sample;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sr_latch_driver.sv
// rtl/sr_latch_driver.sv - debounced, mutually exclusive pulse driver for a NAND SR latch with q feedback check
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int PULSE_W    = 3,
    parameter int GAP_W      = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic reset_req,
    input  logic q_fb,
    output logic set_n,
    output logic reset_n,
    output logic state_o,
    output logic busy,
    output logic mismatch
);

    localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [NUM_REQ-1:0]    rise;
    logic [NUM_REQ-1:0]    pend;
    logic [NUM_REQ-1:0]    start;
    logic [2:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [SYNC_DEPTH-1:0] q_sync;
    logic                  q_s;

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (set_req),
        .rise (rise[REQ_SET])
    );

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rst (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (reset_req),
        .rise (rise[REQ_RST])
    );

    assign start[REQ_RST] = (state == ST_IDLE) && pend[REQ_RST];
    assign start[REQ_SET] = (state == ST_IDLE) && !pend[REQ_RST] && pend[REQ_SET];
    assign busy           = (state != ST_IDLE);
    assign q_s            = q_sync[SYNC_DEPTH-1];

    // A new edge landing on the cycle its pulse starts is kept, not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= rise | (pend & ~start);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_INIT;
            cnt     <= '0;
            set_n   <= 1'b1;
            reset_n <= 1'b1;
            state_o <= 1'b0;
        end else begin
            case (state)
                // INIT starts counting from 0 so its first cycle pulls reset_n low.
                ST_INIT: begin
                    reset_n <= 1'b0;
                    if (cnt == CNT_W'(PULSE_W)) begin
                        reset_n <= 1'b1;
                        state_o <= 1'b0;
                        cnt     <= CNT_W'(1);
                        state   <= ST_GAP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (start[REQ_RST]) begin
                        reset_n <= 1'b0;
                        cnt     <= CNT_W'(1);
                        state   <= ST_PULSE_RST;
                    end else if (start[REQ_SET]) begin
                        set_n <= 1'b0;
                        cnt   <= CNT_W'(1);
                        state <= ST_PULSE_SET;
                    end
                end
                ST_PULSE_SET, ST_PULSE_RST: begin
                    if (cnt == CNT_W'(PULSE_W)) begin
                        set_n   <= 1'b1;
                        reset_n <= 1'b1;
                        state_o <= (state == ST_PULSE_SET);
                        cnt     <= CNT_W'(1);
                        state   <= ST_GAP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt == CNT_W'(GAP_W)) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    set_n   <= 1'b1;
                    reset_n <= 1'b1;
                    cnt     <= '0;
                    state   <= ST_INIT;
                end
            endcase
        end
    end

    // Only compare while the FSM will stay in IDLE, so the flag never leaks into a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sync   <= '0;
            mismatch <= 1'b0;
        end else begin
            q_sync   <= {q_sync[SYNC_DEPTH-2:0], q_fb};
            mismatch <= (state == ST_IDLE) && (pend == '0) && (q_s != state_o);
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb/tb_sr_latch_driver.sv - scoreboard bench for sr_latch_driver with a behavioural NAND latch on q_fb
module tb_sr_latch_driver;

    localparam int PW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic set_req = 1'b0;
    logic reset_req = 1'b0;
    logic q_fb;
    logic set_n, reset_n, state_o, busy, mismatch;

    logic latch_q = 1'b0;
    logic fault = 1'b0;

    int checks = 0;
    int errors = 0;

    // 1 = set pulse expected, 0 = reset pulse expected
    logic exp_q[$];
    int   pulse_w = 0;
    logic pulse_set = 1'b0;

    sr_latch_driver #(.DEB_CYCLES(4), .PULSE_W(PW), .GAP_W(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_req  (set_req),
        .reset_req(reset_req),
        .q_fb     (q_fb),
        .set_n    (set_n),
        .reset_n  (reset_n),
        .state_o  (state_o),
        .busy     (busy),
        .mismatch (mismatch)
    );

    always #5 clk = ~clk;

    always @(set_n or reset_n) begin
        if (set_n === 1'b0 && reset_n === 1'b1) latch_q = 1'b1;
        else if (reset_n === 1'b0 && set_n === 1'b1) latch_q = 1'b0;
    end

    assign q_fb = fault ? 1'b0 : latch_q;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            pulse_w = 0;
        end else begin
            checks++;
            if (set_n === 1'b0 && reset_n === 1'b0) begin
                errors++;
                $display("FAIL both_low: set_n=%b reset_n=%b required not both 0", set_n, reset_n);
            end
            if (set_n === 1'b0 || reset_n === 1'b0) begin
                pulse_set = (set_n === 1'b0);
                pulse_w++;
            end else if (pulse_w > 0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: got set=%b width=%0d required none", pulse_set, pulse_w);
                end else begin
                    logic e;
                    e = exp_q.pop_front();
                    if (pulse_set !== e || pulse_w != PW || state_o !== e) begin
                        errors++;
                        $display("FAIL pulse: got set=%b width=%0d state_o=%b required set=%b width=%0d state_o=%b",
                                 pulse_set, pulse_w, state_o, e, PW, e);
                    end
                end
                pulse_w = 0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({set_n, reset_n, state_o, busy, mismatch} !== 5'b11010) begin
            errors++;
            $display("FAIL reset_values: got %b required 11010", {set_n, reset_n, state_o, busy, mismatch});
        end
        exp_q.push_back(1'b0);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (reset_n !== !(k <= 3) || set_n !== 1'b1 || busy !== (k < 5) || state_o !== 1'b0) begin
                errors++;
                $display("FAIL init_cycle%0d: got reset_n=%b set_n=%b busy=%b state_o=%b required %b 1 %b 0",
                         k, reset_n, set_n, busy, state_o, !(k <= 3), (k < 5));
            end
        end
        idle(4);
    endtask

    task automatic test_set_press;
        exp_q.push_back(1'b1);
        set_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if (set_n !== !(k >= 8 && k <= 10)) begin
                errors++;
                $display("FAIL set_press_cycle%0d: got set_n=%b required %b", k, set_n, !(k >= 8 && k <= 10));
            end
            if (k == 10) set_req = 1'b0;
        end
        checks++;
        if (state_o !== 1'b1) begin
            errors++;
            $display("FAIL set_press_state: got %b required 1", state_o);
        end
        idle(12);
    endtask

    task automatic test_bounce;
        for (int i = 0; i < 3; i++) begin
            set_req = 1'b1;
            idle(2);
            set_req = 1'b0;
            idle(2);
        end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            checks++;
            if (set_n !== 1'b1 || reset_n !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL bounce_cycle%0d: got set_n=%b reset_n=%b busy=%b required 1 1 0", k, set_n, reset_n, busy);
            end
        end
        checks++;
        if (state_o !== 1'b1) begin
            errors++;
            $display("FAIL bounce_state: got %b required 1", state_o);
        end
    endtask

    task automatic test_simultaneous;
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        set_req = 1'b1;
        reset_req = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            checks++;
            if (reset_n !== !(k >= 8 && k <= 10) || set_n !== !(k >= 13 && k <= 15)) begin
                errors++;
                $display("FAIL simul_cycle%0d: got reset_n=%b set_n=%b required %b %b",
                         k, reset_n, set_n, !(k >= 8 && k <= 10), !(k >= 13 && k <= 15));
            end
            if (k == 11 || k == 16) begin
                checks++;
                if (state_o !== (k == 16)) begin
                    errors++;
                    $display("FAIL simul_state%0d: got %b required %b", k, state_o, (k == 16));
                end
            end
            if (k == 10) begin
                set_req = 1'b0;
                reset_req = 1'b0;
            end
        end
        idle(10);
    endtask

    task automatic test_req_during_pulse;
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        set_req = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            checks++;
            if (set_n !== !(k >= 8 && k <= 10) || reset_n !== !(k >= 13 && k <= 15)) begin
                errors++;
                $display("FAIL during_pulse_cycle%0d: got set_n=%b reset_n=%b required %b %b",
                         k, set_n, reset_n, !(k >= 8 && k <= 10), !(k >= 13 && k <= 15));
            end
            if (k == 3) reset_req = 1'b1;
            if (k == 10) set_req = 1'b0;
            if (k == 13) reset_req = 1'b0;
        end
        checks++;
        if (state_o !== 1'b0) begin
            errors++;
            $display("FAIL during_pulse_state: got %b required 0", state_o);
        end
        idle(10);
    endtask

    task automatic test_feedback_fault;
        bit seen;
        exp_q.push_back(1'b1);
        set_req = 1'b1;
        idle(10);
        set_req = 1'b0;
        idle(6);
        checks++;
        if (mismatch !== 1'b0 || state_o !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fb_clean: got mismatch=%b state_o=%b busy=%b required 0 1 0", mismatch, state_o, busy);
        end
        fault = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk);
            if (mismatch === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL fb_fault: got mismatch=%b required 1 within 6 cycles", mismatch);
        end
        fault = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk);
            if (mismatch === 1'b0) seen = 1'b0 || 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL fb_recover: got mismatch=%b required 0 within 6 cycles", mismatch);
        end
        idle(4);
    endtask

    task automatic test_async_reset;
        set_req = 1'b1;
        for (int k = 1; k <= 9; k++) @(negedge clk);
        checks++;
        if (set_n !== 1'b0) begin
            errors++;
            $display("FAIL async_pre: got set_n=%b required 0", set_n);
        end
        #2 rst_n = 1'b0;
        set_req = 1'b0;
        #1;
        checks++;
        if (set_n !== 1'b1 || busy !== 1'b1 || state_o !== 1'b0 || mismatch !== 1'b0) begin
            errors++;
            $display("FAIL async_abort: got set_n=%b busy=%b state_o=%b mismatch=%b required 1 1 0 0",
                     set_n, busy, state_o, mismatch);
        end
        idle(2);
        exp_q.push_back(1'b0);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (reset_n !== !(k <= 3) || set_n !== 1'b1 || busy !== (k < 5)) begin
                errors++;
                $display("FAIL async_init%0d: got reset_n=%b set_n=%b busy=%b required %b 1 %b",
                         k, reset_n, set_n, busy, !(k <= 3), (k < 5));
            end
        end
        idle(10);
    endtask

    initial begin
        test_reset();
        test_set_press();
        test_bounce();
        test_simultaneous();
        test_req_during_pulse();
        test_feedback_fault();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pulses_outstanding: got %0d required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
